// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//
// WIDTH-bit add/subtract built from one 4-bit adder slice. The slice is run
// over the operands one nibble per clock, LSB nibble first. A carry register
// links consecutive nibbles. Subtraction is done as A + ~B + 1: the inverted
// B is latched and the carry register is seeded with 1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request; accepted only when busy=0 (IDLE or DONE cycle)
//   sub        0 = A+B, 1 = A-B; sampled with start
//   op_a       operand A; sampled with start
//   op_b       operand B; sampled with start
//   busy       high while a sequence is running
//   done       one-cycle pulse when result/flags update
//   result     registered sum/difference; holds until the next completion
//   carry_out  carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   overflow   signed overflow of the completed operation

module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    // Holds the nibbles produced so far; the newest nibble enters at the top,
    // so after NIB steps the full result sits aligned in {slice, acc_q}.
    logic [WIDTH-5:0] acc_q;

    logic [4:0]       slice_sum;
    logic [3:0]       slice_low;
    logic             slice_c3;
    logic [WIDTH-1:0] acc_next;
    logic             last_nib;

    always_comb begin
        slice_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
        // Carry into bit 3 of the slice; on the last nibble this is the
        // carry into bit WIDTH-1, needed for signed overflow.
        slice_low = {1'b0, a_q[2:0]} + {1'b0, b_q[2:0]} + {3'b0, carry_q};
        slice_c3  = slice_low[3];
        acc_next  = {slice_sum[3:0], acc_q};
        last_nib  = (cnt_q == CW'(NIB - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    // The DONE cycle accepts a new request just like IDLE,
                    // which gives back-to-back throughput of NIB+1 cycles.
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= sub ? ~op_b : op_b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= {4'b0, a_q[WIDTH-1:4]};
                    b_q     <= {4'b0, b_q[WIDTH-1:4]};
                    acc_q   <= acc_next[WIDTH-1:4];
                    carry_q <= slice_sum[4];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_nib) begin
                        result    <= acc_next;
                        carry_out <= slice_sum[4];
                        overflow  <= slice_c3 ^ slice_sum[4];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencing controller that performs WIDTH-bit add/subtract by running a single 4-bit adder slice (with carry-in) over successive nibbles, LSB first, one nibble per clock.
A carry register links the nibbles.
The block gives the team wide arithmetic at the area cost of one 4-bit slice.
Sits between a requester (start/busy/done handshake) and any consumer of the registered result and flags.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only on an edge where busy=0
sub  input  1  0 = A+B, 1 = A-B; sampled with start
op_a  input  WIDTH  operand A; sampled with start
op_b  input  WIDTH  operand B; sampled with start
busy  output  1  high while a sequence is in progress
done  output  1  one-cycle pulse when result/flags update
result  output  WIDTH  registered sum/difference; holds until the next completion
carry_out  output  1  final carry out of bit WIDTH-1 (for sub: 1 = no borrow)
overflow  output  1  signed overflow of the completed operation

Behaviour:
- Reset: rst_n low forces state IDLE immediately, independent of clk.
  - busy=0, done=0, result=0, carry_out=0, overflow=0.
  - Internal operand shift registers, carry register and nibble counter are cleared.
- FSM states:
  - IDLE: busy=0. On an edge with start=1:
    - latch op_a into shift register A.
    - latch op_b into shift register B, or ~op_b if sub=1.
    - carry register := sub; counter := 0; go to RUN.
  - RUN: busy=1. Each edge:
    - slice computes A[3:0] + B[3:0] + carry.
    - the 4-bit sum shifts into the result accumulator from the MSB end; A and B shift right by 4.
    - carry register := slice carry out; counter increments.
    - On the edge where counter == NIB-1, go to DONE_ST; result, carry_out and overflow load their final values on that same edge.
  - DONE_ST: done=1, busy=0 for exactly one cycle, then IDLE.
    - If start=1 in DONE_ST, it is accepted exactly as in IDLE: operands latched, next state RUN, done still 1 this cycle.
- Latency: start sampled at edge k gives busy=1 from after edge k through edge k+NIB.
  - done=1 and result valid in the cycle after edge k+NIB.
  - Start-to-done is NIB+1 edges; throughput is one op per NIB+1 cycles with back-to-back starts.
- start while busy=1 (RUN) is ignored: no latch, no queueing, no error flag.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - carry_out = carry out of the MSB nibble.
  - overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), computed inside the final nibble using the inverted B for sub.
- Outputs result, carry_out and overflow change only on the completing edge or on reset; they are stable during RUN.
- Reset asserted mid-RUN: the operation is abandoned, no done pulse, all outputs go to reset values.
- sub, op_a and op_b are don't-care except on the accepting edge.

Test Plan:
1. WIDTH=16, reset then start with A=0xFFFF, B=0x0001, sub=0.
   - done exactly 5 edges after the accepting edge; result=0x0000, carry_out=1, overflow=0.
   - busy high for 4 cycles.
2. A=0x7FFF, B=0x0001, sub=0 -> result=0x8000, carry_out=0, overflow=1.
3. A=0x0005, B=0x0007, sub=1 -> result=0xFFFE, carry_out=0, overflow=0.
   - Then A=0x8000, B=0x0001, sub=1 -> result=0x7FFF, carry_out=1, overflow=1.
4. Start A=0x1234, B=0x1111; pulse start again with A=0xFFFF two cycles later (during busy).
   - Only one done; result=0x2345; the second start is ignored.
5. Assert start with new operands (A=0x0F0F, B=0x00F1) in the done cycle of a previous op.
   - Accepted; next done 5 edges later with result=0x1000; previous result holds until then.
6. Drop rst_n asynchronously in the second RUN cycle.
   - busy, done, result, carry_out and overflow are 0 immediately.
   - No done pulse after release; a fresh start completes normally.
